// File: rtl/dm_bus_arbiter_pkg.sv
// Shared definitions for the debug-module system-bus arbiter and its helpers.
package dm_bus_arbiter_pkg;

    // Default bus width used by the packed request record below.
    localparam int unsigned DmBusWidth = 32;

    // Width of an index that selects one of n items (never narrower than 1 bit).
    function automatic int unsigned arb_idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One requester's bus transaction, so per-port inputs can become packed arrays of it.
    typedef struct packed {
        logic [DmBusWidth-1:0]   addr;
        logic                    we;
        logic [DmBusWidth/8-1:0] be;
        logic [DmBusWidth-1:0]   wdata;
    } dm_bus_req_t;

endpackage

// File: rtl/dm_arb_idx_fifo.sv
// Small synchronous-reset FIFO of requester indices. Granted transactions are
// pushed in order, and each in-order response pops the head to find its owner.
module dm_arb_idx_fifo
    import dm_bus_arbiter_pkg::*;
#(
    parameter int unsigned Width = 1,
    parameter int unsigned Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [Width-1:0] head_o
);

    localparam int unsigned PtrW = arb_idx_width(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [CntW-1:0]  r_count;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (r_count == CntW'(Depth));
    assign empty_o = (r_count == '0);
    assign head_o  = r_mem[r_rd_ptr];

    // A push while full or a pop while empty is ignored.
    assign w_push = push_i & ~full_o;
    assign w_pop  = pop_i & ~empty_o;

    // Storage write; only the pointers and count define which entries are valid.
    // NOTE: the storage array has no reset -- stale contents are never read
    // because empty_o guards every pop, and leaving it unreset keeps it plain RAM.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == LastPtr) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LastPtr) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dm_bus_arbiter.sv
// Round-robin arbiter sharing one req/gnt/r_valid bus master port between
// NrPorts requesters. A request presented downstream is locked until granted,
// and responses are routed back in order through an index FIFO.
module dm_bus_arbiter
    import dm_bus_arbiter_pkg::*;
#(
    parameter int unsigned NrPorts        = 2,
    parameter int unsigned BusWidth       = 32,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NrPorts-1:0]              req_i,
    input  logic [NrPorts-1:0]              we_i,
    input  logic [NrPorts*BusWidth-1:0]     addr_i,
    input  logic [NrPorts*BusWidth/8-1:0]   be_i,
    input  logic [NrPorts*BusWidth-1:0]     wdata_i,
    output logic [NrPorts-1:0]              gnt_o,
    output logic [NrPorts-1:0]              r_valid_o,
    output logic [BusWidth-1:0]             r_rdata_o,
    output logic                            master_req_o,
    output logic [BusWidth-1:0]             master_add_o,
    output logic                            master_we_o,
    output logic [BusWidth/8-1:0]           master_be_o,
    output logic [BusWidth-1:0]             master_wdata_o,
    input  logic                            master_gnt_i,
    input  logic                            master_r_valid_i,
    input  logic [BusWidth-1:0]             master_r_rdata_i
);

    localparam int unsigned IdxW = arb_idx_width(NrPorts);
    localparam int unsigned BeW  = BusWidth / 8;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NrPorts - 1);

    logic [IdxW-1:0]     r_rr_ptr;
    logic                r_lock;
    logic [IdxW-1:0]     r_lock_idx;

    logic [IdxW-1:0]     w_rr_sel;
    logic [IdxW-1:0]     w_cand;
    logic                w_found;
    logic [IdxW-1:0]     w_sel;
    logic [IdxW-1:0]     w_next_rr;
    logic                w_grant;
    logic                w_resp;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [IdxW-1:0]     w_fifo_head;

    logic [BusWidth-1:0] w_addr  [NrPorts];
    logic [BusWidth-1:0] w_wdata [NrPorts];
    logic [BeW-1:0]      w_be    [NrPorts];

    // Unpack the flat per-port buses so the output mux is a plain array index.
    for (genvar p = 0; p < NrPorts; p++) begin : g_unpack
        assign w_addr[p]  = addr_i[p*BusWidth +: BusWidth];
        assign w_wdata[p] = wdata_i[p*BusWidth +: BusWidth];
        assign w_be[p]    = be_i[p*BeW +: BeW];
    end

    // Round-robin search: first requesting port at or after r_rr_ptr, wrapping.
    // NOTE: every signal driven here gets a default before the loop so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_rr_sel = r_rr_ptr;
        w_cand   = '0;
        w_found  = 1'b0;
        for (int unsigned i = 0; i < NrPorts; i++) begin
            w_cand = IdxW'((32'(r_rr_ptr) + i) % NrPorts);
            if (!w_found && req_i[w_cand]) begin
                w_rr_sel = w_cand;
                w_found  = 1'b1;
            end
        end
    end

    // A stalled request stays pinned to its port until the slave grants it.
    assign w_sel     = r_lock ? r_lock_idx : w_rr_sel;
    assign w_next_rr = (w_sel == LastIdx) ? '0 : w_sel + 1'b1;

    // Downstream request and payload are a zero-latency mux of the selected port.
    assign master_req_o   = ~rst_i & req_i[w_sel] & ~w_fifo_full;
    assign master_add_o   = w_addr[w_sel];
    assign master_we_o    = we_i[w_sel];
    assign master_be_o    = w_be[w_sel];
    assign master_wdata_o = w_wdata[w_sel];

    assign w_grant   = master_req_o & master_gnt_i;
    assign w_resp    = ~rst_i & master_r_valid_i & ~w_fifo_empty;
    assign r_rdata_o = master_r_rdata_i;

    // Grant goes only to the selected port; response only to the oldest owner.
    always_comb begin
        gnt_o     = '0;
        r_valid_o = '0;
        gnt_o[w_sel]           = w_grant;
        r_valid_o[w_fifo_head] = w_resp;
    end

    // Arbitration state: advance the pointer on grant, lock a stalled request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr_ptr   <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
        end else if (w_grant) begin
            r_rr_ptr <= w_next_rr;
            r_lock   <= 1'b0;
        end else if (master_req_o) begin
            r_lock     <= 1'b1;
            r_lock_idx <= w_sel;
        end
    end

    // Outstanding owners, oldest at the head. A pop in the full cycle does not
    // free a slot for a same-cycle push, costing one bubble.
    dm_arb_idx_fifo #(
        .Width (IdxW),
        .Depth (MaxOutstanding)
    ) u_idx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_grant),
        .data_i  (w_sel),
        .pop_i   (w_resp),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .head_o  (w_fifo_head)
    );

    // Protocol monitors: stray responses and requests withdrawn while locked.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(master_r_valid_i && w_fifo_empty))
                else $warning("dm_bus_arbiter: response with no outstanding transaction");
            assert (!(r_lock && !req_i[r_lock_idx]))
                else $warning("dm_bus_arbiter: locked request withdrawn before grant");
        end
    end

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Directed plus random bench for dm_bus_arbiter, checked against a
// transaction-level model: a queue of owners, a rotating priority and a
// pending-request pin.
module tb_dm_bus_arbiter;

    localparam int N    = 2;
    localparam int BW   = 32;
    localparam int BEW  = BW / 8;
    localparam int MAXO = 2;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [N-1:0]      req_i;
    logic [N-1:0]      we_i;
    logic [N*BW-1:0]   addr_i;
    logic [N*BEW-1:0]  be_i;
    logic [N*BW-1:0]   wdata_i;
    logic [N-1:0]      gnt_o;
    logic [N-1:0]      r_valid_o;
    logic [BW-1:0]     r_rdata_o;
    logic              master_req_o;
    logic [BW-1:0]     master_add_o;
    logic              master_we_o;
    logic [BEW-1:0]    master_be_o;
    logic [BW-1:0]     master_wdata_o;
    logic              master_gnt_i;
    logic              master_r_valid_i;
    logic [BW-1:0]     master_r_rdata_i;

    dm_bus_arbiter #(
        .NrPorts        (N),
        .BusWidth       (BW),
        .MaxOutstanding (MAXO)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .req_i            (req_i),
        .we_i             (we_i),
        .addr_i           (addr_i),
        .be_i             (be_i),
        .wdata_i          (wdata_i),
        .gnt_o            (gnt_o),
        .r_valid_o        (r_valid_o),
        .r_rdata_o        (r_rdata_o),
        .master_req_o     (master_req_o),
        .master_add_o     (master_add_o),
        .master_we_o      (master_we_o),
        .master_be_o      (master_be_o),
        .master_wdata_o   (master_wdata_o),
        .master_gnt_i     (master_gnt_i),
        .master_r_valid_i (master_r_valid_i),
        .master_r_rdata_i (master_r_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Requester side: each port's current transaction.
    logic           p_req   [N];
    logic           p_we    [N];
    logic [BW-1:0]  p_addr  [N];
    logic [BEW-1:0] p_be    [N];
    logic [BW-1:0]  p_wdata [N];
    bit             random_mode;

    // Reference model state.
    int q_owner[$];
    int m_lock;
    int m_rr;

    int n_checks;
    int n_fail;

    // Snapshots of the last sampled cycle for directed checks.
    logic          obs_req;
    logic [N-1:0]  obs_gnt;
    logic [N-1:0]  obs_rv;
    logic [BW-1:0] obs_add;
    logic          obs_we;
    logic [BEW-1:0] obs_be;
    logic [BW-1:0] obs_wdata;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected)
            else begin
                n_fail++;
                $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
            end
    endtask

    task automatic pack();
        for (int i = 0; i < N; i++) begin
            req_i[i]               = p_req[i];
            we_i[i]                = p_we[i];
            addr_i[i*BW +: BW]     = p_addr[i];
            be_i[i*BEW +: BEW]     = p_be[i];
            wdata_i[i*BW +: BW]    = p_wdata[i];
        end
    endtask

    task automatic renew(input int p);
        p_addr[p]  = $urandom;
        p_wdata[p] = $urandom;
        p_be[p]    = BEW'($urandom);
        p_we[p]    = 1'($urandom_range(0, 1));
        if (random_mode) p_req[p] = 1'($urandom_range(0, 1));
    endtask

    // One clock cycle: drive, sample mid-cycle, compare with the model, advance.
    task automatic cycle(input logic g, input logic rv, input logic [BW-1:0] rd);
        int           port;
        bit           full;
        logic         exp_req;
        logic [N-1:0] exp_gnt;
        logic [N-1:0] exp_rv;

        master_gnt_i     = g;
        master_r_valid_i = rv;
        master_r_rdata_i = rd;
        pack();
        #3;

        port    = -1;
        exp_req = 1'b0;
        exp_gnt = '0;
        exp_rv  = '0;
        if (!rst_i) begin
            if (m_lock >= 0) begin
                port = m_lock;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (port < 0 && p_req[(m_rr + k) % N]) port = (m_rr + k) % N;
                end
            end
            full    = (q_owner.size() >= MAXO);
            exp_req = (port >= 0) && p_req[port] && !full;
            if (exp_req && g) exp_gnt = N'(1 << port);
            if (rv && q_owner.size() > 0) exp_rv = N'(1 << q_owner[0]);
        end

        obs_req   = master_req_o;
        obs_gnt   = gnt_o;
        obs_rv    = r_valid_o;
        obs_add   = master_add_o;
        obs_we    = master_we_o;
        obs_be    = master_be_o;
        obs_wdata = master_wdata_o;

        check("master_req", obs_req, exp_req);
        check("gnt", obs_gnt, exp_gnt);
        check("r_valid", obs_rv, exp_rv);
        if (exp_req) begin
            check("addr", obs_add, p_addr[port]);
            check("we", obs_we, p_we[port]);
            check("be", obs_be, p_be[port]);
            check("wdata", obs_wdata, p_wdata[port]);
        end
        if (exp_rv != '0) check("rdata", r_rdata_o, rd);

        @(posedge clk_i);
        #1;

        if (rst_i) begin
            q_owner.delete();
            m_lock = -1;
            m_rr   = 0;
        end else begin
            if (exp_rv != '0) void'(q_owner.pop_front());
            if (exp_gnt != '0) begin
                q_owner.push_back(port);
                m_rr   = (port + 1) % N;
                m_lock = -1;
                renew(port);
            end else if (exp_req) begin
                m_lock = port;
            end
        end
    endtask

    // Return every outstanding response with nobody requesting.
    task automatic drain();
        for (int i = 0; i < N; i++) p_req[i] = 1'b0;
        for (int i = 0; i < 2 * MAXO && q_owner.size() > 0; i++) cycle(1'b0, 1'b1, $urandom);
        check("drained", 64'(q_owner.size()), 64'd0);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        random_mode = 1'b0;
        m_lock      = -1;
        m_rr        = 0;
        for (int i = 0; i < N; i++) begin
            renew(i);
            p_req[i] = 1'b1;
        end
        rst_i = 1'b1;
        #1;

        // Reset held with every port requesting: nothing may leak out.
        repeat (3) cycle(1'b1, 1'b0, '0);
        rst_i = 1'b0;
        cycle(1'b1, 1'b0, '0);
        check("first_grant_port0", obs_gnt, 2'b01);

        // Continuous contention with a one-cycle response: grants alternate.
        for (int i = 0; i < 8; i++) cycle(1'b1, q_owner.size() > 0, $urandom);
        drain();

        // Port 1 stalled at 0x1000 while port 0 arrives: request stays pinned.
        p_req[1]  = 1'b1;
        p_addr[1] = 32'h0000_1000;
        cycle(1'b0, 1'b0, '0);
        p_req[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, '0);
            check("locked_addr", obs_add, 32'h0000_1000);
        end
        cycle(1'b1, 1'b0, '0);
        check("locked_grant_port1", obs_gnt, 2'b10);
        p_req[1] = 1'b0;
        cycle(1'b1, 1'b0, '0);
        check("next_grant_port0", obs_gnt, 2'b01);
        drain();

        // FIFO full with responses withheld, then one response reopens it.
        p_req[0] = 1'b1;
        p_req[1] = 1'b1;
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        check("full_blocks_req", obs_req, 1'b0);
        cycle(1'b1, 1'b1, 32'hA5A5_0001);
        check("full_pop_no_push", obs_req, 1'b0);
        cycle(1'b1, 1'b0, '0);
        check("regrant_after_pop", obs_req, 1'b1);
        drain();

        // Single write from port 0 passes through untouched.
        p_req[0]   = 1'b1;
        p_we[0]    = 1'b1;
        p_be[0]    = 4'hF;
        p_wdata[0] = 32'hDEAD_BEEF;
        p_addr[0]  = 32'h0000_2000;
        cycle(1'b1, 1'b0, '0);
        check("write_wdata", obs_wdata, 32'hDEAD_BEEF);
        check("write_we", obs_we, 1'b1);
        check("write_be", obs_be, 4'hF);
        p_req[0] = 1'b0;
        cycle(1'b0, 1'b1, 32'h1234_5678);
        check("write_resp_port0", obs_rv, 2'b01);

        // Reset with two transactions in flight discards them.
        p_req[0] = 1'b1;
        p_req[1] = 1'b1;
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        rst_i    = 1'b1;
        p_req[0] = 1'b0;
        p_req[1] = 1'b0;
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);
        rst_i = 1'b0;
        cycle(1'b0, 1'b1, 32'hBAD0_BAD0);
        check("stray_resp_ignored", obs_rv, 2'b00);
        p_req[0] = 1'b1;
        p_req[1] = 1'b1;
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        check("fresh_fifo_second_grant", obs_req, 1'b1);
        cycle(1'b1, 1'b0, '0);
        check("fresh_fifo_full", obs_req, 1'b0);
        drain();

        // Random traffic: requests held until granted, random stalls and responses.
        random_mode = 1'b1;
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!p_req[i] && $urandom_range(0, 2) == 0) p_req[i] = 1'b1;
            end
            cycle(1'($urandom_range(0, 3) != 0),
                  (q_owner.size() > 0) && ($urandom_range(0, 1) == 1),
                  $urandom);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
